baccarat_sequencer: RTL and testbench

Control FSM for the baccarat card-game datapath. It drives the six card-register load strobes in dealing order and applies the Punto Banco third-card rules using the live hand scores and the player's third card. It lights the winner LEDs when the hand ends. It sits beside the datapath on the same slow clock; the datapath computes scores, and this block decides only which card to load next.

---
 rtl/baccarat_pkg.sv | 34 +++
 rtl/banker_draw_rule.sv | 28 ++
 rtl/baccarat_sequencer.sv | 104 ++++++++++
 tb/tb_baccarat_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat control sequencer.
// Scores and ranks are unsigned 4-bit quantities throughout.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_P1   = 4'd1,
    S_D1   = 4'd2,
    S_P2   = 4'd3,
    S_D2   = 4'd4,
    S_EVAL = 4'd5,
    S_P3   = 4'd6,
    S_BANK = 4'd7,
    S_D3   = 4'd8,
    S_END  = 4'd9
  } state_e;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] BANKER_STAND    = 4'd7;
  localparam logic [3:0] FACE_RANK_MIN   = 4'd10;

  // Tens and face cards count as zero in baccarat.
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    logic [3:0] value;
    if (rank >= FACE_RANK_MIN) begin
      value = 4'd0;
    end else begin
      value = rank;
    end
    return value;
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Punto Banco banker third-card table, evaluated after the player has drawn.
// Purely combinational: draw is valid whenever dscore and pcard3 are.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] value_s;

  assign value_s = rank_value(pcard3);

  // Banker decision indexed by banker total, qualified by player's third-card value.
  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (value_s != 4'd8);
      4'd4:             draw = (value_s >= 4'd2) && (value_s <= 4'd7);
      4'd5:             draw = (value_s >= 4'd4) && (value_s <= 4'd7);
      4'd6:             draw = (value_s >= 4'd6) && (value_s <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// Moore control FSM for the baccarat datapath: sequences card load strobes,
// applies the third-card rules and lights the winner LEDs at the end of a hand.
module baccarat_sequencer
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  state_e state_q;
  state_e state_d;
  logic   banker_draw_s;

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; S_EVAL and S_BANK decide from the live datapath scores.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_P1;
      S_P1:   state_d = S_D1;
      S_D1:   state_d = S_P2;
      S_P2:   state_d = S_D2;
      S_D2:   state_d = S_EVAL;
      S_EVAL: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          state_d = S_END;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          state_d = S_P3;
        end else if (dscore <= PLAYER_DRAW_MAX) begin
          state_d = S_D3;
        end else begin
          state_d = S_END;
        end
      end
      S_P3:   state_d = S_BANK;
      S_BANK: begin
        if (banker_draw_s && (dscore < BANKER_STAND)) begin
          state_d = S_D3;
        end else begin
          state_d = S_END;
        end
      end
      S_D3:   state_d = S_END;
      S_END:  state_d = S_END;
      default: state_d = S_RST;
    endcase
  end

  // Moore outputs: strobes decode the state; lights follow the final scores in S_END.
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    done             = 1'b0;
    case (state_q)
      S_P1: load_pcard1 = 1'b1;
      S_D1: load_dcard1 = 1'b1;
      S_P2: load_pcard2 = 1'b1;
      S_D2: load_dcard2 = 1'b1;
      S_P3: load_pcard3 = 1'b1;
      S_D3: load_dcard3 = 1'b1;
      S_END: begin
        done             = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Directed self-checking bench for baccarat_sequencer; the bench plays the datapath
// by driving pscore/dscore/pcard3 with hand-computed values.
module tb_baccarat_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;
  logic [8:0] obs;

  int checks = 0;
  int passes = 0;

  localparam logic [8:0] O_P1 = 9'h100;
  localparam logic [8:0] O_D1 = 9'h080;
  localparam logic [8:0] O_P2 = 9'h040;
  localparam logic [8:0] O_D2 = 9'h020;
  localparam logic [8:0] O_P3 = 9'h010;
  localparam logic [8:0] O_D3 = 9'h008;
  localparam logic [8:0] O_PW = 9'h004;
  localparam logic [8:0] O_DW = 9'h002;
  localparam logic [8:0] O_DN = 9'h001;
  localparam logic [8:0] O_NONE = 9'h000;

  baccarat_sequencer dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done)
  );

  assign obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
                load_dcard3, player_win_light, dealer_win_light, done};

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // Expected strobe for edges 1..5 after reset release (initial deal).
  function automatic logic [8:0] deal_exp(input int e);
    case (e)
      1: return O_P1;
      2: return O_D1;
      3: return O_P2;
      4: return O_D2;
      default: return O_NONE;
    endcase
  endfunction

  // Holds reset for two edges, then releases it; no checking here.
  task automatic start_hand();
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  // Walks edges 1..5 to reach S_EVAL, checking the initial deal strobes.
  task automatic deal_checked(input string name);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (obs !== deal_exp(e)) $display("FAIL %s deal edge %0d: got %b expected %b", name, e, obs, deal_exp(e));
      else passes++;
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== O_NONE) $display("FAIL reset hold %0d: got %b expected %b", i, obs, O_NONE);
      else passes++;
    end
    resetb = 1'b1;
    deal_checked("reset_release");
  endtask

  task automatic test_natural();
    start_hand();
    deal_checked("natural");
    pscore = 4'd8;
    dscore = 4'd3;
    tick();
    checks++;
    if (obs !== (O_DN | O_PW)) $display("FAIL natural edge 6: got %b expected %b", obs, O_DN | O_PW);
    else passes++;
    tick();
    checks++;
    if (obs !== (O_DN | O_PW)) $display("FAIL natural hold: got %b expected %b", obs, O_DN | O_PW);
    else passes++;
  endtask

  task automatic test_player_banker_draw();
    start_hand();
    deal_checked("pdraw_bdraw");
    pscore = 4'd4;
    dscore = 4'd4;
    tick();
    checks++;
    if (obs !== O_P3) $display("FAIL pdraw_bdraw edge 6: got %b expected %b", obs, O_P3);
    else passes++;
    pcard3 = 4'd7;
    pscore = 4'd1;
    tick();
    checks++;
    if (obs !== O_NONE) $display("FAIL pdraw_bdraw edge 7: got %b expected %b", obs, O_NONE);
    else passes++;
    tick();
    checks++;
    if (obs !== O_D3) $display("FAIL pdraw_bdraw edge 8: got %b expected %b", obs, O_D3);
    else passes++;
    dscore = 4'd7;
    tick();
    checks++;
    if (obs !== (O_DN | O_DW)) $display("FAIL pdraw_bdraw edge 9: got %b expected %b", obs, O_DN | O_DW);
    else passes++;
  endtask

  task automatic test_player_draw_face();
    start_hand();
    deal_checked("pdraw_face");
    pscore = 4'd4;
    dscore = 4'd4;
    tick();
    checks++;
    if (obs !== O_P3) $display("FAIL pdraw_face edge 6: got %b expected %b", obs, O_P3);
    else passes++;
    pcard3 = 4'd12;
    tick();
    checks++;
    if (obs !== O_NONE) $display("FAIL pdraw_face edge 7: got %b expected %b", obs, O_NONE);
    else passes++;
    tick();
    checks++;
    if (obs !== (O_DN | O_PW | O_DW)) $display("FAIL pdraw_face edge 8: got %b expected %b", obs, O_DN | O_PW | O_DW);
    else passes++;
  endtask

  task automatic test_player_stands();
    start_hand();
    deal_checked("pstand_bdraw");
    pscore = 4'd6;
    dscore = 4'd5;
    tick();
    checks++;
    if (obs !== O_D3) $display("FAIL pstand_bdraw edge 6: got %b expected %b", obs, O_D3);
    else passes++;
    dscore = 4'd2;
    tick();
    checks++;
    if (obs !== (O_DN | O_PW)) $display("FAIL pstand_bdraw edge 7: got %b expected %b", obs, O_DN | O_PW);
    else passes++;

    start_hand();
    deal_checked("pstand_bstand");
    pscore = 4'd6;
    dscore = 4'd7;
    tick();
    checks++;
    if (obs !== (O_DN | O_DW)) $display("FAIL pstand_bstand edge 6: got %b expected %b", obs, O_DN | O_DW);
    else passes++;
  endtask

  task automatic test_tie_and_banker_win();
    start_hand();
    deal_checked("tie");
    pscore = 4'd6;
    dscore = 4'd6;
    tick();
    checks++;
    if (obs !== (O_DN | O_PW | O_DW)) $display("FAIL tie edge 6: got %b expected %b", obs, O_DN | O_PW | O_DW);
    else passes++;

    start_hand();
    deal_checked("banker_win");
    pscore = 4'd2;
    dscore = 4'd9;
    tick();
    checks++;
    if (obs !== (O_DN | O_DW)) $display("FAIL banker_win edge 6: got %b expected %b", obs, O_DN | O_DW);
    else passes++;
  endtask

  // Banker table through S_BANK: {dscore, pcard3 rank, expected draw}.
  task automatic test_banker_table();
    logic [3:0] tbl_d [10] = '{4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd0};
    logic [3:0] tbl_c [10] = '{4'd8, 4'd9, 4'd1, 4'd2, 4'd4, 4'd8, 4'd6, 4'd5, 4'd7, 4'd10};
    logic       tbl_x [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0] exp8;
    for (int k = 0; k < 10; k++) begin
      start_hand();
      for (int e = 1; e <= 5; e++) tick();
      pscore = 4'd0;
      dscore = tbl_d[k];
      tick();
      pcard3 = tbl_c[k];
      tick();
      tick();
      if (tbl_x[k]) exp8 = O_D3;
      else exp8 = O_DN | ((tbl_d[k] == 4'd0) ? (O_PW | O_DW) : O_DW);
      checks++;
      if (obs !== exp8) $display("FAIL banker_table d=%0d c=%0d: got %b expected %b", tbl_d[k], tbl_c[k], obs, exp8);
      else passes++;
    end
  endtask

  task automatic test_mid_hand_reset();
    start_hand();
    deal_checked("midreset");
    pscore = 4'd3;
    dscore = 4'd0;
    tick();
    checks++;
    if (obs !== O_P3) $display("FAIL midreset in P3: got %b expected %b", obs, O_P3);
    else passes++;
    resetb = 1'b0;
    tick();
    checks++;
    if (obs !== O_NONE) $display("FAIL midreset reset edge: got %b expected %b", obs, O_NONE);
    else passes++;
    pscore = 4'd0;
    resetb = 1'b1;
    tick();
    checks++;
    if (obs !== O_P1) $display("FAIL midreset restart P1: got %b expected %b", obs, O_P1);
    else passes++;
    tick();
    checks++;
    if (obs !== O_D1) $display("FAIL midreset restart D1: got %b expected %b", obs, O_D1);
    else passes++;
  endtask

  task automatic test_reset_in_end();
    start_hand();
    for (int e = 1; e <= 5; e++) tick();
    pscore = 4'd9;
    dscore = 4'd1;
    tick();
    resetb = 1'b0;
    tick();
    checks++;
    if (obs !== O_NONE) $display("FAIL reset_in_end: got %b expected %b", obs, O_NONE);
    else passes++;
    resetb = 1'b1;
  endtask

  initial begin
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    test_reset();
    test_natural();
    test_player_banker_draw();
    test_player_draw_face();
    test_player_stands();
    test_tie_and_banker_win();
    test_banker_table();
    test_mid_hand_reset();
    test_reset_in_end();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
